// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, reads one ROM word per cycle into a small queue for decode.
// Optional end-of-ROM halt is enabled with `define FETCH_BOUNDS_CHECK_EN; otherwise the PC wraps within the ROM.
module fetch_ctrl #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned MEM_SIZE = 1024,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_en,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        deq_valid,
    input  logic        deq_ready,
    output logic [31:0] deq_instr,
    output logic [63:0] deq_pc,
    output logic        fetch_halted
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    typedef enum logic {
        RUN,
        HALT
    } state_t;

    state_t          state;
    logic [63:0]     pc;
    logic [AW-1:0]   head;
    logic [AW-1:0]   tail;
    logic [AW:0]     count;
    logic [31:0]     q_instr [DEPTH];
    logic [63:0]     q_pc    [DEPTH];

    logic            deq_fire;
    logic            room;
    logic            oob;
    logic            enq;
    logic [63:0]     pc_next;
    logic [63:0]     redir_tgt;
    logic            unused_lsbs;

    assign unused_lsbs = ^redirect_pc[1:0];

    always_comb begin
        deq_fire = (count != '0) && deq_ready;
        room     = (count < DEPTH_C) || deq_fire;
`ifdef FETCH_BOUNDS_CHECK_EN
        // 65-bit compare so a PC near the top of the address space cannot wrap into range
        oob       = ({1'b0, pc} + 65'd3) >= 65'(MEM_SIZE);
        pc_next   = pc + 64'd4;
        redir_tgt = {redirect_pc[63:2], 2'b00};
`else
        oob       = 1'b0;
        pc_next   = (pc + 64'd4) & (64'(MEM_SIZE) - 64'd1);
        redir_tgt = {redirect_pc[63:2], 2'b00} & (64'(MEM_SIZE) - 64'd1);
`endif
        enq = (state == RUN) && fetch_en && !redirect_valid && !oob && room;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            pc    <= RESET_PC;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (redirect_valid) begin
            state <= RUN;
            pc    <= redir_tgt;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (deq_fire)
                head <= head + 1'b1;
            if (enq) begin
                tail <= tail + 1'b1;
                pc   <= pc_next;
            end
            case ({enq, deq_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (state == RUN && oob)
                state <= HALT;
        end
    end

    // Payload storage needs no reset: count gates visibility of every entry.
    always_ff @(posedge clk) begin
        if (!reset && enq) begin
            q_instr[tail] <= imem_instr;
            q_pc[tail]    <= pc;
        end
    end

    assign imem_addr = pc;
    assign deq_valid = (count != '0);
    assign deq_instr = deq_valid ? q_instr[head] : '0;
    assign deq_pc    = deq_valid ? q_pc[head] : '0;

`ifdef FETCH_BOUNDS_CHECK_EN
    assign fetch_halted = (state == HALT);
`else
    assign fetch_halted = 1'b0;
`endif

endmodule
